rca_rr_sched: RTL
=================

Name: rca_rr_sched

Overview:
- Round-robin scheduler that shares one 4-bit ripple-carry adder slice (rcadut: a, b, cin in; sum, carry out) between NREQ requesters.
- Accepts one request at a time over a valid/ready handshake and registers the operands onto the adder inputs.
- Captures the adder result one cycle later and returns it, tagged with the requester ID, over a valid/ready response channel.
- Sits between requesting blocks and the single shared combinational adder instance.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- IDW, $clog2(NREQ), width of the requester ID. Derived; do not override.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NREQ  per-requester request valid.
- req_a  input  4*NREQ  operand a; requester i uses bits [4i+3:4i].
- req_b  input  4*NREQ  operand b; same packing as req_a.
- req_cin  input  NREQ  carry-in per requester.
- req_ready  output  NREQ  one-hot grant/accept strobe.
- add_a  output  4  registered operand a to the shared adder.
- add_b  output  4  registered operand b to the shared adder.
- add_cin  output  1  registered carry-in to the shared adder.
- add_sum  input  4  sum from the shared adder (combinational).
- add_carry  input  1  carry from the shared adder.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_sum  output  4  captured sum.
- rsp_carry  output  1  captured carry.
- rsp_id  output  IDW  index of the requester served.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- FSM states: IDLE, EXEC, RESP. State and every register are async-cleared by rst_n low.
- Reset values: state=IDLE; add_a, add_b, add_cin = 0; rsp_valid, rsp_sum, rsp_carry, rsp_id = 0; busy=0; last_gnt = NREQ-1, so requester 0 has top priority after reset.
- req_ready is combinational. It is nonzero only in IDLE, and only the single winner bit is set.
  - Winner = first i with req_valid[i]=1, searching (last_gnt+1) mod NREQ upward with wrap-around.
  - req_ready is 0 while rst_n is low.
- IDLE:
  - If any req_valid is high, the handshake completes on that clock edge.
  - The winner's a/b/cin are latched into add_a/add_b/add_cin, winner index into rsp_id and last_gnt, and the FSM moves to EXEC.
  - If no req_valid is high, the FSM stays in IDLE.
- EXEC (exactly 1 cycle): the adder settles combinationally; at the clock edge add_sum/add_carry are captured into rsp_sum/rsp_carry, rsp_valid goes to 1, and the FSM moves to RESP.
- RESP:
  - rsp_valid, rsp_sum, rsp_carry and rsp_id are held stable until rsp_valid && rsp_ready.
  - On that edge rsp_valid goes to 0 and the FSM returns to IDLE.
  - No new request is accepted in the same cycle.
- Throughput is one transaction per 3 cycles minimum. Latency from request handshake to rsp_valid is 2 edges.
- add_a/add_b/add_cin retain their last value outside EXEC; they are not cleared after use.
- Requesters hold valid and operands stable until their req_ready is seen. A valid dropped before grant is simply never served; there is no error.
- Requesters not granted see req_ready=0 and wait. Fairness: a continuously asserting requester waits at most NREQ-1 grants.
- rsp_ready high during IDLE or EXEC is ignored.
- Any rst_n assertion mid-transaction aborts it: the response is lost, rsp_valid drops immediately (asynchronously), and last_gnt returns to NREQ-1.
- Arithmetic is {rsp_carry, rsp_sum} = add_a + add_b + add_cin, computed by the external adder. The scheduler does no arithmetic.

Optional Feature:
- Macro RCA_RR_SCHED_TRACE_EN.
- When defined, the block prints a simulation-only $display line:
  - on each request handshake: time, granted ID, a, b, cin;
  - on each response handshake: time, ID, sum, carry.
  - Format is "[time] [RCA_RR_SCHED] ...".
- When undefined, no display code is compiled and behaviour and ports are identical.

Test Plan:
- Reset, then req_valid=4'b0001 with a=3, b=4, cin=1 on req0, rsp_ready=1 -> req_ready=4'b0001 in that cycle; two edges later rsp_valid=1, rsp_sum=8, rsp_carry=0, rsp_id=0.
- Overflow: req2 with a=15, b=15, cin=1 -> rsp_sum=15, rsp_carry=1, rsp_id=2.
- All four requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,…, and req_ready is never multi-hot.
- Back-pressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* stay stable, req_ready=0 throughout, busy=1; the next grant occurs only after rsp_ready=1.
- Sparse pattern: last grant 3, then req_valid=4'b1010 -> grant 1, then grant 3.
- Assert rst_n=0 during EXEC -> rsp_valid=0 and busy=0 immediately; the next request from req0 and req1 is granted to req0.

Source files
------------

// File: rtl/rca_rr_sched_if.sv
// rtl/rca_rr_sched_if.sv - request/response handshake bundle for rca_rr_sched
interface rca_rr_sched_if #(
    parameter int NREQ = 4
) ();
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [4*NREQ-1:0] req_a;
    logic [4*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_cin;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [3:0]        rsp_sum;
    logic              rsp_carry;
    logic [IDW-1:0]    rsp_id;

    modport master (
        output req_valid, req_a, req_b, req_cin, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_carry, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cin, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_carry, rsp_id
    );
endinterface

// File: rtl/rca_rr_sched.sv
// rtl/rca_rr_sched.sv - round-robin scheduler sharing one 4-bit ripple-carry adder slice
// Optional handshake trace: define RCA_RR_SCHED_TRACE_EN.
module rca_rr_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic           clk,
    input  logic           rst_n,
    rca_rr_sched_if.slave  bus,
    output logic [3:0]     add_a,
    output logic [3:0]     add_b,
    output logic           add_cin,
    input  logic [3:0]     add_sum,
    input  logic           add_carry,
    output logic           busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state_q;
    state_t         state_d;
    logic [IDW-1:0] last_gnt;
    logic [IDW-1:0] win_idx;
    logic           win_found;
    logic           accept;
    logic [IDW-1:0] cand;

    // Search starts just past the last grant, so the previous winner ranks last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(last_gnt) + k) % NREQ);
            if (!win_found && bus.req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign accept = (state_q == IDLE) && win_found;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_found) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (bus.rsp_valid && bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        if (rst_n && accept) begin
            bus.req_ready = NREQ'(1) << win_idx;
        end
        busy = (state_q != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_a         <= '0;
            add_b         <= '0;
            add_cin       <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_sum   <= '0;
            bus.rsp_carry <= 1'b0;
            bus.rsp_id    <= '0;
            last_gnt      <= IDW'(NREQ - 1);
        end else begin
            if (accept) begin
                add_a      <= bus.req_a[{win_idx, 2'b00} +: 4];
                add_b      <= bus.req_b[{win_idx, 2'b00} +: 4];
                add_cin    <= bus.req_cin[win_idx];
                bus.rsp_id <= win_idx;
                last_gnt   <= win_idx;
            end
            if (state_q == EXEC) begin
                bus.rsp_sum   <= add_sum;
                bus.rsp_carry <= add_carry;
                bus.rsp_valid <= 1'b1;
            end
            if (state_q == RESP && bus.rsp_ready) begin
                bus.rsp_valid <= 1'b0;
            end
        end
    end

`ifdef RCA_RR_SCHED_TRACE_EN
    always @(posedge clk) begin
        if (rst_n && accept) begin
            $display("[%0t] [RCA_RR_SCHED] grant id=%0d a=%0d b=%0d cin=%0d", $time, win_idx,
                     bus.req_a[{win_idx, 2'b00} +: 4], bus.req_b[{win_idx, 2'b00} +: 4],
                     bus.req_cin[win_idx]);
        end
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            $display("[%0t] [RCA_RR_SCHED] response id=%0d sum=%0d carry=%0d", $time, bus.rsp_id,
                     bus.rsp_sum, bus.rsp_carry);
        end
    end
`else
`endif
endmodule
